// File: rtl/led_pkg.sv
// Shared types for the switch-parity LED blinker: the LED controller state
// encoding and the mapping from state to LED drive level.
package led_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    STEADY    = 2'd1,
    BLINK_ON  = 2'd2,
    BLINK_OFF = 2'd3
  } led_state_e;

  function automatic logic led_level(input led_state_e state);
    return (state == STEADY) || (state == BLINK_ON);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: two-flop synchronizer followed by a saturating
// stable-count debouncer that only accepts a level held DEB_CYCLES cycles.
module sw_debounce #(
  parameter int DEB_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic stable
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);

  logic             sync_meta;
  logic             sync_out;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchronizer into a single stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= sw;
      sync_out  <= sync_meta;
      if (sync_out == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This is the DEB_CYCLES-th consecutive differing cycle.
        stable <= sync_out;
        cnt    <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_parity_blinker.sv
// Debounces N_SW switches, registers their XOR parity and drives an LED that
// is off, steady or blinking depending on parity and the mode input.
module switch_parity_blinker
  import led_pkg::*;
#(
  parameter int N_SW       = 2,
  parameter int DEB_CYCLES = 120000,
  parameter int BLINK_DIV  = 6000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw,
  input  logic            mode,
  output logic            led,
  output logic            parity
);

  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [N_SW-1:0]    stable_bits;
  led_state_e         state;
  led_state_e         state_next;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_next;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw[i]),
      .stable(stable_bits[i])
    );
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    blink_cnt_next = '0;
    unique case (state)
      OFF: begin
        if (parity) begin
          state_next = mode ? BLINK_ON : STEADY;
        end
      end
      STEADY: begin
        if (!parity) begin
          state_next = OFF;
        end else if (mode) begin
          state_next = BLINK_ON;
        end
      end
      BLINK_ON, BLINK_OFF: begin
        if (!parity) begin
          state_next = OFF;
        end else if (!mode) begin
          state_next = STEADY;
        end else if (blink_cnt == BLINK_LAST) begin
          state_next = (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end else begin
          blink_cnt_next = blink_cnt + 1'b1;
        end
      end
      default: state_next = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= OFF;
      blink_cnt <= '0;
      parity    <= 1'b0;
      led       <= 1'b0;
    end else begin
      state     <= state_next;
      blink_cnt <= blink_cnt_next;
      parity    <= ^stable_bits;
      led       <= led_level(state);
    end
  end

endmodule

// File: doc/switch_parity_blinker.md
SWITCH_PARITY_BLINKER -- requirements
Module: switch_parity_blinker

Interface
REQ-001 SHALL have parameter N_SW, default 2: number of switch inputs, legal range 1..16.
REQ-002 SHALL have parameter DEB_CYCLES, default 120000: stable-cycle count for debounce, minimum 1.
REQ-003 SHALL have parameter BLINK_DIV, default 6000000: clock cycles per LED half-period, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port sw, input, N_SW bits: asynchronous switch levels.
REQ-007 SHALL have port mode, input, 1 bit: 0 = steady LED, 1 = blinking LED; synchronous to clk.
REQ-008 SHALL have port led, output, 1 bit: registered LED drive.
REQ-009 SHALL have port parity, output, 1 bit: registered XOR of all debounced switch bits.

Function
REQ-010 SHALL pass each sw bit through a 2-flop synchronizer.
REQ-011 SHALL keep one debounced "stable" bit per switch.
- stable updates only after the synchronized value differs from stable for DEB_CYCLES consecutive cycles.
- Any cycle where they are equal clears that switch's counter.
REQ-012 SHALL make the debounce counter width $clog2(DEB_CYCLES+1) and saturate it, never wrap.
REQ-013 SHALL register parity as the XOR of all stable bits, one cycle after a stable bit changes.
- Worst-case sw-to-parity latency: 2 + DEB_CYCLES + 1 cycles.
REQ-014 SHALL implement FSM states OFF, STEADY, BLINK_ON, BLINK_OFF.
REQ-015 SHALL apply these transitions from OFF:
- parity=1 & mode=0 -> STEADY.
- parity=1 & mode=1 -> BLINK_ON, with the blink counter cleared.
REQ-016 SHALL move from any non-OFF state to OFF on the next cycle when parity=0; this has priority over every other transition.
REQ-017 SHALL move STEADY -> BLINK_ON (counter cleared) when mode=1.
REQ-018 SHALL move BLINK_ON or BLINK_OFF -> STEADY when mode=0.
REQ-019 SHALL run the blink counter 0..BLINK_DIV-1 only in BLINK_ON/BLINK_OFF.
- At count BLINK_DIV-1, counter wraps to 0 and the state toggles BLINK_ON <-> BLINK_OFF.
- Width is $clog2(BLINK_DIV).
REQ-020 SHALL register led = 1 in STEADY and BLINK_ON, 0 otherwise, one cycle after the state.
REQ-021 SHALL hold the blink counter at 0 in OFF and STEADY.

Reset
REQ-022 SHALL, on rst_n=0 at a clk edge, clear the synchronizers, stable bits, debounce counters and blink counter, set state to OFF, and drive led=0 and parity=0.
REQ-023 SHALL abandon any debounce or blink in progress on reset mid-operation, with no residual state.
REQ-024 SHALL treat sw as 0 for the first 2 cycles after reset release.

Structure
REQ-025 SHALL place the FSM state enum (2 bits) in shared package led_pkg.
REQ-026 SHALL put synchronizer plus debounce in sub-module sw_debounce (param DEB_CYCLES), instantiated N_SW times by generate.

Verification (DEB_CYCLES=4, BLINK_DIV=3, N_SW=2 unless stated)
REQ-027 SHALL cover: sw=01 held from reset release -> parity=1 on cycle 7 after the change, led=1 on the cycle after the FSM leaves OFF (mode=0).
REQ-028 SHALL cover: sw[0] glitches 1 for 3 cycles then returns to 0 -> stable, parity and led never change.
REQ-029 SHALL cover: mode=1, parity=1 -> led pattern 1,1,1,0,0,0 repeating (3-cycle half-periods), first high phase full length.
REQ-030 SHALL cover:
- parity falls during BLINK_OFF -> state OFF next cycle, led=0, counter=0.
- parity rising again -> restarts in BLINK_ON.
REQ-031 SHALL cover: mode toggled 1->0 mid-BLINK_OFF -> led=1 two cycles later; back to 1 -> fresh full BLINK_ON phase.
REQ-032 SHALL cover: rst_n=0 asserted mid-blink with sw=11 -> led=0 and parity=0 the cycle after; after release with sw=11 held, parity stays 0 (XOR=0).
